greater_than: RTL and testbench
===============================

GREATER_THAN -- requirements
Module: greater_than

Interface
REQ-001 Parameter WIDTH, default 2, operand width in bits; legal range 1..32.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port in_valid  input  1  qualifies A and B in the current cycle.
REQ-005 Port A  input  WIDTH  first operand.
REQ-006 Port B  input  WIDTH  second operand.
REQ-007 Port out_valid  output  1  F, EQ and LT carry a fresh result.
REQ-008 Port F  output  1  registered (A > B).
REQ-009 Port EQ  output  1  registered (A == B).
REQ-010 Port LT  output  1  registered (A < B).

Function
REQ-011 Comparison SHALL be unsigned magnitude over all WIDTH bits; no truncation or extension.
REQ-012 Result latency SHALL be exactly 1 cycle: operands sampled at edge N appear on F/EQ/LT with out_valid=1 after edge N.
REQ-013 Exactly one of F, EQ, LT SHALL be 1 whenever out_valid=1.
REQ-014 out_valid SHALL equal in_valid delayed by one cycle; no backpressure, one result accepted every cycle.
REQ-015 When in_valid=0, F/EQ/LT SHALL hold their previous values and out_valid SHALL be 0.
REQ-016 Back-to-back valid operands SHALL produce back-to-back results with no bubbles.
REQ-017 Boundaries: A=B=0 gives EQ=1; A=all-ones, B=0 gives F=1; A=0, B=all-ones gives LT=1.
REQ-018 Comparison SHALL be computed MSB-first: the most significant differing bit decides. It is built as a tree of 2-bit slice compares so the combinational depth is O(log2 WIDTH).

Reset
REQ-019 rst_n=0 SHALL immediately clear out_valid, F, EQ and LT to 0, independent of clk.
REQ-020 Deassertion of rst_n SHALL be taken synchronously to clk. The first sample occurs on the first rising edge with rst_n=1.
REQ-021 Reset asserted mid-stream SHALL discard any pending result. No out_valid pulse SHALL follow reset release unless in_valid was 1 at a post-release edge.

Configuration
REQ-022 Macro GREATER_THAN_SIGNED_EN defined: A and B SHALL be compared as two's-complement signed values, so for WIDTH=2, A=2'b10 (-2) < B=2'b01 (+1) gives LT=1.
REQ-023 Macro GREATER_THAN_SIGNED_EN undefined: comparison SHALL be unsigned per REQ-011.
REQ-024 Latency, handshake and reset behaviour SHALL be identical in both builds.

Structure
REQ-025 Package greater_than_pkg SHALL hold the cmp_res_t typedef (2-bit enum CMP_LT, CMP_EQ, CMP_GT), the WIDTH bounds and the slice-merge function.
REQ-026 Sub-module cmp_slice SHALL compare one 2-bit operand pair and emit cmp_res_t.
REQ-027 The top SHALL instantiate ceil(WIDTH/2) cmp_slice instances and reduce their results MSB-priority into the output registers.
REQ-028 Odd WIDTH SHALL zero-extend the top slice, or sign-extend it under GREATER_THAN_SIGNED_EN.

Verification
REQ-029 WIDTH=2, unsigned build, drive {A,B}=0..15 with in_valid=1 for one cycle each, 20 ns apart -> F=1 exactly for A>B, e.g. {A,B}=4'd9 (A=2, B=1) gives F=1 and {A,B}=4'd6 (A=1, B=2) gives F=0.
REQ-030 Hold rst_n=0, then toggle inputs -> out_valid=F=EQ=LT=0 throughout. Assert rst_n mid-clock -> outputs clear before the next edge.
REQ-031 Drive in_valid 1,0,1 with A=3,B=0 then A=0,B=3 -> out_valid pulses 1,0,1; F=1 holds during the gap; then LT=1.
REQ-032 WIDTH=8, A=8'h80, B=8'h7F -> F=1 unsigned build; LT=1 with GREATER_THAN_SIGNED_EN.
REQ-033 WIDTH=5, random 1000 operand pairs, continuous in_valid -> results match a reference model one cycle later; one-hot F/EQ/LT every valid cycle.

Source files
------------

// File: rtl/greater_than_pkg.sv
// Shared types and helpers for the greater_than magnitude comparator.
// The top-level build option is GREATER_THAN_SIGNED_EN (two's-complement compare).
package greater_than_pkg;

  localparam int GT_WIDTH_MIN = 1;
  localparam int GT_WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_GT = 2'd2
  } cmp_res_t;

  // The more significant half decides unless it is equal.
  function automatic cmp_res_t cmp_merge(input cmp_res_t hi, input cmp_res_t lo);
    return (hi == CMP_EQ) ? lo : hi;
  endfunction

endpackage

// File: rtl/greater_than_cmp_slice.sv
// Two-bit unsigned compare, the leaf of the greater_than reduction tree.
module cmp_slice
  import greater_than_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  output cmp_res_t   res
);

  always_comb begin
    res = CMP_EQ;
    if (a > b) begin
      res = CMP_GT;
    end else if (a < b) begin
      res = CMP_LT;
    end
  end

endmodule

// File: rtl/greater_than.sv
// Registered A-vs-B compare built as a log-depth tree of 2-bit slices.
// Define GREATER_THAN_SIGNED_EN to compare A and B as two's-complement values.
module greater_than
  import greater_than_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic             F,
  output logic             EQ,
  output logic             LT
);

  localparam int NS = (WIDTH + 1) / 2;
  localparam int EW = 2 * NS;
  localparam int NL = (NS <= 1) ? 1 : (1 << $clog2(NS));
  localparam int LV = $clog2(NL);

  logic [EW-1:0] w_a_ext;
  logic [EW-1:0] w_b_ext;
  cmp_res_t      w_root;

  logic r_valid;
  logic r_f;
  logic r_eq;
  logic r_lt;

  always_comb begin
`ifdef GREATER_THAN_SIGNED_EN
    w_a_ext = EW'($signed(A));
    w_b_ext = EW'($signed(B));
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    w_a_ext[EW-1] = ~w_a_ext[EW-1];
    w_b_ext[EW-1] = ~w_b_ext[EW-1];
`else
    w_a_ext = EW'(A);
    w_b_ext = EW'(B);
`endif
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi <= LV; gi++) begin : g_lvl
      localparam int N = NL >> gi;
      cmp_res_t w_res [N];
      if (gi == 0) begin : g_leaf
        // Index 0 is the most significant slice; padding leaves sit at the low end.
        for (gj = 0; gj < NL; gj++) begin : g_slice
          if (gj < NS) begin : g_real
            cmp_slice u_slice (
              .a   (w_a_ext[2*(NS-1-gj) +: 2]),
              .b   (w_b_ext[2*(NS-1-gj) +: 2]),
              .res (w_res[gj])
            );
          end else begin : g_pad
            assign w_res[gj] = CMP_EQ;
          end
        end
      end else begin : g_merge
        for (gj = 0; gj < N; gj++) begin : g_node
          assign w_res[gj] = cmp_merge(g_lvl[gi-1].w_res[2*gj], g_lvl[gi-1].w_res[2*gj+1]);
        end
      end
    end
  endgenerate

  assign w_root = g_lvl[LV].w_res[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_f     <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_f  <= (w_root == CMP_GT);
        r_eq <= (w_root == CMP_EQ);
        r_lt <= (w_root == CMP_LT);
      end
    end
  end

  assign out_valid = r_valid;
  assign F         = r_f;
  assign EQ        = r_eq;
  assign LT        = r_lt;

endmodule

// File: tb/tb_greater_than.sv
// Directed and random checks of greater_than at WIDTH 2, 5 and 8 against an arithmetic model.
module tb_greater_than;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iv = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic [4:0] a5 = '0, b5 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic ov2, f2, eq2, lt2;
  logic ov5, f5, eq5, lt5;
  logic ov8, f8, eq8, lt8;
  logic [3:0] e2 = '0, e5 = '0, e8 = '0;
  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  greater_than #(.WIDTH(2)) u_w2 (.clk(clk), .rst_n(rst_n), .in_valid(iv), .A(a2), .B(b2),
                                  .out_valid(ov2), .F(f2), .EQ(eq2), .LT(lt2));
  greater_than #(.WIDTH(5)) u_w5 (.clk(clk), .rst_n(rst_n), .in_valid(iv), .A(a5), .B(b5),
                                  .out_valid(ov5), .F(f5), .EQ(eq5), .LT(lt5));
  greater_than #(.WIDTH(8)) u_w8 (.clk(clk), .rst_n(rst_n), .in_valid(iv), .A(a8), .B(b8),
                                  .out_valid(ov8), .F(f8), .EQ(eq8), .LT(lt8));

  // Returns {gt, eq, lt} from the integer values of the operands.
  function automatic logic [2:0] ref_cmp(input logic [31:0] a, input logic [31:0] b, input int w);
    longint sa, sb;
    sa = longint'(a);
    sb = longint'(b);
`ifdef GREATER_THAN_SIGNED_EN
    if (a[w-1]) sa = sa - (longint'(1) << w);
    if (b[w-1]) sb = sb - (longint'(1) << w);
`endif
    return {sa > sb, sa == sb, sa < sb};
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed {v,F,EQ,LT}=%b expected %b", tag, obs, exp);
    end
    if (obs[3] === 1'b1) begin
      n_tests++;
      assert ($onehot(obs[2:0])) else begin
        n_fail++;
        $error("FAIL %s_onehot: observed {F,EQ,LT}=%b expected one-hot", tag, obs[2:0]);
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_w2"}, {ov2, f2, eq2, lt2}, e2);
    chk({tag, "_w5"}, {ov5, f5, eq5, lt5}, e5);
    chk({tag, "_w8"}, {ov8, f8, eq8, lt8}, e8);
  endtask

  // Predict the effect of the coming edge, take it, then check just after it.
  task automatic tick(input string tag);
    if (!rst_n) begin
      e2 = '0; e5 = '0; e8 = '0;
    end else if (iv) begin
      e2 = {1'b1, ref_cmp(32'(a2), 32'(b2), 2)};
      e5 = {1'b1, ref_cmp(32'(a5), 32'(b5), 5)};
      e8 = {1'b1, ref_cmp(32'(a8), 32'(b8), 8)};
    end else begin
      e2[3] = 1'b0; e5[3] = 1'b0; e8[3] = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic randomize_ops();
    a2 = 2'($urandom); b2 = 2'($urandom);
    a5 = 5'($urandom); b5 = 5'($urandom);
    a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  initial begin
    // Reset held while inputs toggle.
    for (int i = 0; i < 3; i++) begin
      iv = i[0];
      randomize_ops();
      tick("in_reset");
    end
    #4 rst_n = 1'b1;
    iv = 1'b0;
    tick("post_release_idle");

    // Exhaustive 2-bit sweep, one valid cycle each.
    for (int v = 0; v < 16; v++) begin
      logic [3:0] vv;
      vv = 4'(v);
      iv = 1'b1;
      a2 = vv[3:2]; b2 = vv[1:0];
      a5 = 5'($urandom); b5 = 5'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom);
      tick("sweep");
      $display("[TB] sweep A=%0d B=%0d F=%0b EQ=%0b LT=%0b", a2, b2, f2, eq2, lt2);
    end

    // Valid gap: results hold while out_valid drops.
    iv = 1'b1; a2 = 2'd3; b2 = 2'd0; a5 = 5'd31; b5 = 5'd0; a8 = 8'hFF; b8 = 8'h00;
    tick("gap_first");
    iv = 1'b0; a2 = 2'd0; b2 = 2'd3; a5 = 5'd0; b5 = 5'd31; a8 = 8'h00; b8 = 8'hFF;
    tick("gap_hold");
    iv = 1'b1;
    tick("gap_second");

    // Boundary operands on every width.
    iv = 1'b1; a2 = '0; b2 = '0; a5 = '0; b5 = '0; a8 = '0; b8 = '0;
    tick("bnd_zero");
    a2 = '1; a5 = '1; a8 = '1;
    tick("bnd_max_zero");
    a2 = '0; b2 = '1; a5 = '0; b5 = '1; a8 = '0; b8 = '1;
    tick("bnd_zero_max");

    // 0x80 vs 0x7F: sign bit alone decides.
    a8 = 8'h80; b8 = 8'h7F;
    tick("w8_80_7f");
    n_tests++;
`ifdef GREATER_THAN_SIGNED_EN
    assert ({f8, lt8} === 2'b01) else begin
      n_fail++;
      $error("FAIL w8_80_7f_direct: observed F,LT=%b%b expected 01", f8, lt8);
    end
`else
    assert ({f8, lt8} === 2'b10) else begin
      n_fail++;
      $error("FAIL w8_80_7f_direct: observed F,LT=%b%b expected 10", f8, lt8);
    end
`endif

    // Mid-cycle reset clears outputs before the next edge and drops the pending result.
    iv = 1'b1; randomize_ops();
    tick("pre_reset");
    randomize_ops();
    #8 rst_n = 1'b0;
    #1;
    e2 = '0; e5 = '0; e8 = '0;
    check_all("async_clear");
    tick("reset_held");
    #5 rst_n = 1'b1;
    iv = 1'b0;
    tick("release_no_pulse");
    iv = 1'b1; randomize_ops();
    tick("release_first_sample");

    // Continuous random traffic.
    for (int i = 0; i < 1000; i++) begin
      randomize_ops();
      iv = 1'b1;
      tick("random");
    end
    iv = 1'b0;
    tick("tail_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
